res_buf: RTL and testbench
==========================

RES_BUF -- requirements
Module: res_buf

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, >= 2.
REQ-002 Parameter WARMUP, default 4, clock cycles discarded after reset release while the upstream pipeline fills; range 0..255.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s1  input  8  accumulator result from upstream stage.
REQ-006 s2  input  8  product result from upstream stage.
REQ-007 in_valid  input  1  s1/s2 pair valid this cycle.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 out_data  output  16  head entry, {s1,s2}, s1 in [15:8].
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  consumer takes the head entry.
REQ-012 count  output  clog2(DEPTH+1)  current occupancy.
REQ-013 overflow  output  1  sticky flag: a valid pair was dropped.
REQ-014 clr_ovf  input  1  clears overflow.
REQ-015 max_s1, max_s2  output  8 each  running maxima (see Configuration).

Function
REQ-016 FSM SHALL have two states, WARM and CAPT; WARM is entered on reset.
REQ-017 WARM: an 8-bit counter SHALL increment once per cycle; transition to CAPT occurs on the edge where the counter reaches WARMUP-1; with WARMUP=0 the FSM SHALL enter CAPT on the first edge after rst deasserts. CAPT persists until reset.
REQ-018 In WARM, in_valid SHALL be ignored: no push, overflow not set, maxima not updated.
REQ-019 in_ready SHALL equal (state==CAPT) && !full, where full means count==DEPTH.
REQ-020 Push: in CAPT, in_valid && !full SHALL write {s1,s2} at the write pointer and advance it modulo DEPTH.
REQ-021 Drop: in CAPT, in_valid && full SHALL discard the pair and set overflow. full is evaluated before this cycle's pop, so a pop in the same cycle does not admit the push.
REQ-022 out_valid SHALL equal count!=0; out_data SHALL show the entry at the read pointer, combinationally from storage.
REQ-023 Pop: out_valid && out_ready SHALL advance the read pointer modulo DEPTH; out_ready while empty SHALL have no effect.
REQ-024 Latency: a pair pushed on edge N SHALL be visible on out_data/out_valid after edge N, if the FIFO was empty.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push only +1; pop only -1.
REQ-026 Entries SHALL leave in strict arrival order across pointer wrap-around.
REQ-027 clr_ovf SHALL clear overflow on the next edge; if a drop occurs in the same cycle, set SHALL win.

Reset
REQ-028 rst high SHALL, on the next edge, force: state WARM, warm counter 0, pointers 0, count 0, overflow 0, max_s1/max_s2 0, and discard stored entries (out_valid 0). out_data is don't-care while out_valid is 0.
REQ-029 Reset asserted mid-operation SHALL take priority over push, pop and clr_ovf in that cycle.

Configuration
REQ-030 Macro RES_BUF_MAX_EN defined: on every accepted push, max_s1/max_s2 SHALL update to the unsigned max of the current value and the pushed s1/s2. Dropped pairs SHALL not update the maxima.
REQ-031 Macro RES_BUF_MAX_EN undefined: max_s1 and max_s2 SHALL be constant 0, and no comparator logic is built.

Verification
REQ-032 Warm-up: rst 1 for 2 cycles, then 0; in_valid=1, s1=8'h10, s2=8'h20 every cycle -> no push for the first 4 cycles; the first out_data is 16'h1020 after cycle 5; in_ready low for exactly 4 cycles.
REQ-033 Fill/overflow: out_ready=0, push 5 pairs 1..5 (s1=s2=k) -> count=4, in_ready=0, overflow=1; drain yields 16'h0101..16'h0404; pair 5 is never output.
REQ-034 Wrap: with out_ready=1 every cycle, stream 10 pairs (s1=k, s2=2k) -> outputs in order, one cycle latency, count stays at most 1, overflow=0.
REQ-035 Full plus pop: at count=4, assert in_valid and out_ready together -> pop occurs, push dropped, count=3, overflow=1; the following cycle clr_ovf=1 with no drop -> overflow=0.
REQ-036 Reset mid-run: at count=3, pulse rst for 1 cycle -> out_valid=0, count=0, overflow=0, FSM re-enters WARM; the 4-cycle warm-up repeats.
REQ-037 With RES_BUF_MAX_EN: push s1 in the order 3, 200, 7 -> max_s1=200; a dropped s1=255 leaves max_s1=200. Without the macro -> max_s1 and max_s2 remain 0.

Source files
------------

// File: rtl/res_buf_if.sv
// Bundle of the upstream pair/handshake, the output head and the status signals of res_buf.
// The slave modport is the buffer itself; the master modport is whoever drives and consumes it.
interface res_buf_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    s1;
  logic [7:0]    s2;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_ovf;
  logic [7:0]    max_s1;
  logic [7:0]    max_s2;

  modport slave (
    input  s1, s2, in_valid, out_ready, clr_ovf,
    output in_ready, out_data, out_valid, count, overflow, max_s1, max_s2
  );

  modport master (
    output s1, s2, in_valid, out_ready, clr_ovf,
    input  in_ready, out_data, out_valid, count, overflow, max_s1, max_s2
  );
endinterface

// File: rtl/res_buf.sv
// res_buf: result buffer behind the accumulator/multiplier stages.
// After reset it ignores its input for WARMUP cycles while the upstream pipeline fills,
// then captures {s1,s2} pairs into a DEPTH-entry FIFO, dropping (and flagging) pairs when full.
// Optional feature: define RES_BUF_MAX_EN to track the running unsigned maxima of accepted s1/s2;
// without it max_s1/max_s2 are tied to zero and no comparators exist.
module res_buf #(
  parameter int DEPTH  = 4,
  parameter int WARMUP = 4
) (
  input logic      clk,
  input logic      rst,
  res_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

  typedef enum logic {WARM, CAPT} state_e;

  state_e        state_q, state_d;
  logic [7:0]    warm_cnt_q, warm_cnt_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          capt;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic          warm_done;

  assign warm_done = (WARMUP == 0) || (warm_cnt_q == WARM_LAST);

  // State register: warm-up phase entered on reset, counter restarts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WARM;
      warm_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Next-state: leave WARM once the counter has covered the warm-up window; CAPT is terminal
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      WARM: begin
        warm_cnt_d = warm_cnt_q + 8'd1;
        if (warm_done) state_d = CAPT;
      end
      CAPT: state_d = CAPT;
    endcase
  end

  // FSM outputs and handshake decode; full is judged before any same-cycle pop
  always_comb begin
    capt = (state_q == CAPT);
    full = (count_q == CW'(DEPTH));
    push = capt && bus.in_valid && !full;
    drop = capt && bus.in_valid && full;
    pop  = (count_q != '0) && bus.out_ready;
  end

  // Datapath next-state: pointers wrap naturally since DEPTH is a power of two; drop beats clear
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  // Datapath registers: reset empties the FIFO by clearing pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage: contents need no reset because out_valid masks stale data
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= {bus.s1, bus.s2};
  end

`ifdef RES_BUF_MAX_EN
  logic [7:0] max1_q, max1_d;
  logic [7:0] max2_q, max2_d;

  // Running maxima follow accepted pushes only; dropped pairs never reach them
  always_comb begin
    max1_d = max1_q;
    max2_d = max2_q;
    if (push) begin
      if (bus.s1 > max1_q) max1_d = bus.s1;
      if (bus.s2 > max2_q) max2_d = bus.s2;
    end
  end

  // Maxima registers, cleared with the rest of the block
  always_ff @(posedge clk) begin
    if (rst) begin
      max1_q <= 8'd0;
      max2_q <= 8'd0;
    end else begin
      max1_q <= max1_d;
      max2_q <= max2_d;
    end
  end

  assign bus.max_s1 = max1_q;
  assign bus.max_s2 = max2_q;
`else
  assign bus.max_s1 = 8'd0;
  assign bus.max_s2 = 8'd0;
`endif

  assign bus.in_ready  = capt && !full;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = mem_q[rptr_q];
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_res_buf.sv
// Testbench for res_buf: directed scenarios plus a randomized phase, all checked against a
// queue-based reference model that tracks warm-up time, FIFO contents, overflow and maxima.
// Honours RES_BUF_MAX_EN the same way the design does.
module tb_res_buf;
  localparam int DEPTH  = 4;
  localparam int WARMUP = 4;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mQueue[$];
  int          mWarmLeft;
  bit          mOvf;
  logic [7:0]  mMax1;
  logic [7:0]  mMax2;

  res_buf_if #(.DEPTH(DEPTH)) bus ();

  res_buf #(.DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Model of one clock edge, driven purely from the stimulus values
  task automatic modelStep(input logic r, input logic inV, input logic [7:0] a, input logic [7:0] b,
                           input logic outR, input logic clr);
    bit isFull;
    bit dropNow;
    if (r) begin
      mQueue.delete();
      mWarmLeft = (WARMUP == 0) ? 1 : WARMUP;
      mOvf      = 1'b0;
      mMax1     = 8'd0;
      mMax2     = 8'd0;
      return;
    end
    dropNow = 1'b0;
    if (mWarmLeft > 0) begin
      mWarmLeft--;
    end else begin
      isFull  = (mQueue.size() == DEPTH);
      dropNow = inV && isFull;
      if (outR && mQueue.size() != 0) void'(mQueue.pop_front());
      if (inV && !isFull) begin
        mQueue.push_back({a, b});
`ifdef RES_BUF_MAX_EN
        if (a > mMax1) mMax1 = a;
        if (b > mMax2) mMax2 = b;
`endif
      end
    end
    if (dropNow)  mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
  endtask

  // Compare every observable output against the model
  task automatic checkModel();
    bit expValid;
    expValid = (mQueue.size() != 0);
    checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
    checkOutput("count", 32'(bus.count), 32'(mQueue.size()));
    checkOutput("in_ready", 32'(bus.in_ready), 32'((mWarmLeft == 0) && (mQueue.size() < DEPTH)));
    checkOutput("overflow", 32'(bus.overflow), 32'(mOvf));
    if (expValid) checkOutput("out_data", 32'(bus.out_data), 32'(mQueue[0]));
    checkOutput("max_s1", 32'(bus.max_s1), 32'(mMax1));
    checkOutput("max_s2", 32'(bus.max_s2), 32'(mMax2));
  endtask

  // Drive one cycle of inputs, step the model at the edge, check just after it
  task automatic applyStimulus(input logic r, input logic inV, input logic [7:0] a, input logic [7:0] b,
                               input logic outR, input logic clr);
    rst           = r;
    bus.in_valid  = inV;
    bus.s1        = a;
    bus.s2        = b;
    bus.out_ready = outR;
    bus.clr_ovf   = clr;
    @(posedge clk);
    modelStep(r, inV, a, b, outR, clr);
    #1;
    checkModel();
  endtask

  // Two-cycle reset followed by the idle warm-up window
  task automatic resetAndWarm();
    repeat (2) applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (WARMUP) applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  // Push k=1..n with s1=s2=k and no consumer
  task automatic fillPairs(input int n);
    for (int k = 1; k <= n; k++) applyStimulus(1'b0, 1'b1, 8'(k), 8'(k), 1'b0, 1'b0);
  endtask

  // Scenario sequence
  initial begin
    logic [7:0] expMax;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.s1        = 8'd0;
    bus.s2        = 8'd0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;

    // Warm-up: valid pairs offered from reset release, first accepted after WARMUP cycles
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_count", 32'(bus.count), 32'd0);
    for (int c = 0; c < WARMUP; c++) begin
      applyStimulus(1'b0, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
      checkOutput("warm_nopush", 32'(bus.count), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    checkOutput("warm_first", 32'(bus.out_data), 32'h1020);
    checkOutput("warm_count", 32'(bus.count), 32'd1);

    // Fill and overflow, then drain in order
    resetAndWarm();
    fillPairs(5);
    checkOutput("fill_count", 32'(bus.count), 32'd4);
    checkOutput("fill_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("fill_ovf", 32'(bus.overflow), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("drain_data", 32'(bus.out_data), 32'({8'(k), 8'(k)}));
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(bus.out_valid), 32'd0);

    // Streaming across pointer wrap with a permanent consumer
    resetAndWarm();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b1, 8'(k), 8'(2 * k), 1'b1, 1'b0);
      checkOutput("wrap_data", 32'(bus.out_data), 32'({8'(k), 8'(2 * k)}));
      checkOutput("wrap_count", 32'(bus.count), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("wrap_ovf", 32'(bus.overflow), 32'd0);

    // Full plus pop: the push is still dropped, then clr_ovf clears the flag
    resetAndWarm();
    fillPairs(4);
    applyStimulus(1'b0, 1'b1, 8'd9, 8'd9, 1'b1, 1'b0);
    checkOutput("fullpop_count", 32'(bus.count), 32'd3);
    checkOutput("fullpop_ovf", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    checkOutput("clr_ovf", 32'(bus.overflow), 32'd0);

    // Reset mid-run at count 3 beats push/pop/clear and restarts the warm-up
    applyStimulus(1'b1, 1'b1, 8'd7, 8'd7, 1'b1, 1'b1);
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_count", 32'(bus.count), 32'd0);
    for (int c = 0; c < WARMUP; c++) begin
      checkOutput("midrst_warm", 32'(bus.in_ready), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'd7, 8'd7, 1'b0, 1'b0);
    end
    checkOutput("midrst_ready", 32'(bus.in_ready), 32'd1);

    // Maxima: accepted 3,200,7,1 then a dropped 255
    resetAndWarm();
    applyStimulus(1'b0, 1'b1, 8'd3, 8'd30, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd200, 8'd5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd7, 8'd70, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
`ifdef RES_BUF_MAX_EN
    expMax = 8'd200;
`else
    expMax = 8'd0;
`endif
    checkOutput("max_after_drop", 32'(bus.max_s1), 32'(expMax));

    // Randomized traffic with occasional clears and resets
    resetAndWarm();
    for (int c = 0; c < 600; c++) begin
      applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
                    8'($urandom), 8'($urandom), ($urandom_range(0, 99) < 45),
                    ($urandom_range(0, 99) < 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
